fb_arbiter: RTL and testbench

- Arbitrates a single-port frame-buffer memory between two requesters.
- Display fetch port: VGA scan-out side, fetches 32-bit words of four 8-bit pixels. Writer port: drawing/host side.
- Display has priority; the writer gets a bounded-wait guarantee. Reads are returned through a fixed-latency registered pipeline.
- Sits between the pixel generator's word fetch and the frame-buffer memory, on the system clock domain.

---
 rtl/fb_arbiter_if.sv | 44 ++++
 rtl/fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_arbiter_if.sv
// Bundles the display-fetch, writer and frame-buffer memory signals of fb_arbiter.
// slave is the arbiter's view; master is the view of the surrounding requesters and memory.
interface fb_arbiter_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 32
) ();

  // Display fetch port
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_ack;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  // Writer port
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;

  // Frame-buffer memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Underrun status
  logic              clr_underrun;
  logic              underrun;

  modport slave (
    input  disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata, clr_underrun,
    output disp_ack, disp_rvalid, disp_rdata, wr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, underrun
  );

  modport master (
    output disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata, clr_underrun,
    input  disp_ack, disp_rvalid, disp_rdata, wr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, underrun
  );

endinterface

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: display reads have priority, the writer has a bounded wait,
// and read data returns through a fixed-latency registered pipeline.
module fb_arbiter #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned DEADLINE    = 6,
  parameter int unsigned WR_MAX_WAIT = 16
) (
  input logic          clock,
  input logic          reset,
  fb_arbiter_if.slave  io_bus
);

  localparam int unsigned WrWaitW   = $clog2(WR_MAX_WAIT + 1);
  localparam int unsigned DispWaitW = $clog2(DEADLINE + 1);

  typedef enum logic [0:0] {StArb, StWrTurn} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [WrWaitW-1:0]    r_wr_wait;
  logic [DispWaitW-1:0]  r_disp_wait;
  logic                  r_underrun;
  logic [RD_LAT:0]       r_rd_vld;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_wr_starved;
  logic                  w_grant_wr;
  logic                  w_grant_rd;
  logic                  w_underrun_set;
  logic [RD_LAT+1:0]     w_vld_tap;

  assign w_wr_starved   = io_bus.wr_req && (r_wr_wait == WrWaitW'(WR_MAX_WAIT));
  assign w_underrun_set = io_bus.disp_req && !w_grant_rd &&
                          (r_disp_wait == DispWaitW'(DEADLINE));

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StArb;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: any issued write buys exactly one write-only cycle afterwards
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StArb:    w_state_next = w_grant_wr ? StWrTurn : StArb;
      StWrTurn: w_state_next = w_grant_wr ? StWrTurn : StArb;
      default:  w_state_next = StArb;
    endcase
  end

  // Output logic: grant selection and memory command; held quiet during reset
  always_comb begin
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    if (!reset) begin
      case (r_state)
        StArb: begin
          if (w_wr_starved) begin
            w_grant_wr = 1'b1;
          end else if (io_bus.disp_req) begin
            w_grant_rd = 1'b1;
          end else if (io_bus.wr_req) begin
            w_grant_wr = 1'b1;
          end
        end
        StWrTurn: w_grant_wr = io_bus.wr_req;
        default: begin
          w_grant_wr = 1'b0;
          w_grant_rd = 1'b0;
        end
      endcase
    end

    io_bus.mem_en    = w_grant_wr || w_grant_rd;
    io_bus.mem_we    = w_grant_wr;
    io_bus.mem_addr  = '0;
    io_bus.mem_wdata = '0;
    if (w_grant_wr) begin
      io_bus.mem_addr  = io_bus.wr_addr;
      io_bus.mem_wdata = io_bus.wr_data;
    end else if (w_grant_rd) begin
      io_bus.mem_addr  = io_bus.disp_addr;
    end
    io_bus.disp_ack  = w_grant_rd;
    io_bus.wr_ack    = w_grant_wr;
  end

  // Writer wait counter, saturating; the saturated value forces the writer through
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_wait <= '0;
    end else if (!io_bus.wr_req || w_grant_wr) begin
      r_wr_wait <= '0;
    end else if (r_wr_wait != WrWaitW'(WR_MAX_WAIT)) begin
      r_wr_wait <= r_wr_wait + WrWaitW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_disp_wait <= '0;
    end else if (!io_bus.disp_req || w_grant_rd) begin
      r_disp_wait <= '0;
    end else if (r_disp_wait != DispWaitW'(DEADLINE)) begin
      r_disp_wait <= r_disp_wait + DispWaitW'(1);
    end
  end

  // Sticky underrun; a new violation outranks a simultaneous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_set) begin
      r_underrun <= 1'b1;
    end else if (io_bus.clr_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  // Tap k of w_vld_tap marks a read issued k cycles ago: tap RD_LAT samples memory,
  // tap RD_LAT+1 presents the result.
  assign w_vld_tap = {r_rd_vld, w_grant_rd};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_vld <= '0;
      r_rdata  <= '0;
    end else begin
      r_rd_vld <= w_vld_tap[RD_LAT:0];
      if (w_vld_tap[RD_LAT]) begin
        r_rdata <= io_bus.mem_rdata;
      end
    end
  end

  assign io_bus.disp_rvalid = w_vld_tap[RD_LAT+1];
  assign io_bus.disp_rdata  = r_rdata;
  assign io_bus.underrun    = r_underrun;

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(w_grant_rd && w_grant_wr));
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed self-checking bench for fb_arbiter with a registered one-cycle memory model.
module tb_fb_arbiter;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 32;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem_model [0:511];

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .RD_LAT      (1),
    .DEADLINE    (6),
    .WR_MAX_WAIT (16)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clock = ~clock;

  // Frame-buffer memory with one cycle of read latency
  always @(posedge clock) begin
    if (bus.mem_en && bus.mem_we) mem_model[bus.mem_addr[8:0]] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem_model[bus.mem_addr[8:0]];
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_req     = 1'b0;
    bus.disp_addr    = '0;
    bus.wr_req       = 1'b0;
    bus.wr_addr      = '0;
    bus.wr_data      = '0;
    bus.clr_underrun = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    @(negedge clock);
    n_checks++;
    if ({bus.mem_en, bus.mem_we, bus.disp_ack, bus.wr_ack, bus.disp_rvalid, bus.underrun}
        !== 6'b0) begin
      n_errors++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {bus.mem_en, bus.mem_we, bus.disp_ack, bus.wr_ack, bus.disp_rvalid,
                bus.underrun});
    end
    n_checks++;
    if (bus.mem_addr !== 17'h0 || bus.mem_wdata !== 32'h0 || bus.disp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_buses: got addr %h wdata %h rdata %h expected all zero",
               bus.mem_addr, bus.mem_wdata, bus.disp_rdata);
    end
    cyc();
    bus.disp_req = 1'b1;
    bus.wr_req   = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus.mem_en, bus.disp_ack, bus.wr_ack} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_gated: got en/dack/wack %b expected 000",
               {bus.mem_en, bus.disp_ack, bus.wr_ack});
    end
    cyc();
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00010;
    @(negedge clock);
    n_checks++;
    if ({bus.disp_ack, bus.mem_en, bus.mem_we} !== 3'b110 || bus.mem_addr !== 17'h00010) begin
      n_errors++;
      $display("FAIL read_cmd: got ack/en/we %b addr %h expected 110 addr 00010",
               {bus.disp_ack, bus.mem_en, bus.mem_we}, bus.mem_addr);
    end
    cyc();
    bus.disp_req = 1'b0;
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL read_early: got rvalid %b expected 0", bus.disp_rvalid);
    end
    cyc();
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 32'hAABBCCDD) begin
      n_errors++;
      $display("FAIL read_return: got rvalid %b data %h expected 1 data aabbccdd",
               bus.disp_rvalid, bus.disp_rdata);
    end
    cyc();
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b0 || bus.disp_rdata !== 32'hAABBCCDD) begin
      n_errors++;
      $display("FAIL read_hold: got rvalid %b data %h expected 0 data aabbccdd",
               bus.disp_rvalid, bus.disp_rdata);
    end
    cyc();
  endtask

  task automatic test_starvation();
    logic [1:0] exp_grant;
    for (int c = 0; c < 19; c++) begin
      bus.disp_req  = 1'b1;
      bus.disp_addr = 17'h00020;
      bus.wr_req    = (c <= 16);
      bus.wr_addr   = 17'h001F0;
      bus.wr_data   = 32'hCAFEF00D;
      if (c < 16 || c == 18) exp_grant = 2'b10;
      else if (c == 16)      exp_grant = 2'b01;
      else                   exp_grant = 2'b00;
      @(negedge clock);
      n_checks++;
      if ({bus.disp_ack, bus.wr_ack} !== exp_grant) begin
        n_errors++;
        $display("FAIL starve_cycle%0d: got dack/wack %b expected %b",
                 c, {bus.disp_ack, bus.wr_ack}, exp_grant);
      end
      if (c == 18) begin
        n_checks++;
        if (bus.underrun !== 1'b0) begin
          n_errors++;
          $display("FAIL starve_underrun: got %b expected 0", bus.underrun);
        end
      end
      cyc();
    end
    idle_inputs();
    cyc();
    cyc();
    cyc();
  endtask

  task automatic test_write_then_read();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 17'h00100;
    bus.wr_data = 32'h12345678;
    @(negedge clock);
    n_checks++;
    if ({bus.wr_ack, bus.mem_en, bus.mem_we} !== 3'b111 || bus.mem_addr !== 17'h00100 ||
        bus.mem_wdata !== 32'h12345678) begin
      n_errors++;
      $display("FAIL wtr_write: got ack/en/we %b addr %h data %h expected 111 00100 12345678",
               {bus.wr_ack, bus.mem_en, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
    end
    cyc();
    bus.wr_req    = 1'b0;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00100;
    @(negedge clock);
    n_checks++;
    if ({bus.disp_ack, bus.mem_en} !== 2'b00) begin
      n_errors++;
      $display("FAIL wtr_turn_block: got dack/en %b expected 00", {bus.disp_ack, bus.mem_en});
    end
    cyc();
    @(negedge clock);
    n_checks++;
    if (bus.disp_ack !== 1'b1 || bus.mem_addr !== 17'h00100) begin
      n_errors++;
      $display("FAIL wtr_read_cmd: got dack %b addr %h expected 1 00100",
               bus.disp_ack, bus.mem_addr);
    end
    cyc();
    bus.disp_req = 1'b0;
    cyc();
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== 32'h12345678 ||
        bus.underrun !== 1'b0) begin
      n_errors++;
      $display("FAIL wtr_data: got rvalid %b data %h underrun %b expected 1 12345678 0",
               bus.disp_rvalid, bus.disp_rdata, bus.underrun);
    end
    cyc();
  endtask

  task automatic test_underrun_chain();
    logic [1:0] exp_grant;
    logic       exp_ur;
    for (int c = 0; c < 12; c++) begin
      bus.wr_req       = (c <= 6);
      bus.wr_addr      = 17'h00180 + 17'(c);
      bus.wr_data      = 32'(c);
      bus.disp_req     = (c >= 1 && c <= 8);
      bus.disp_addr    = 17'h00030;
      bus.clr_underrun = (c == 10);
      if (c <= 6)      exp_grant = 2'b01;
      else if (c == 8) exp_grant = 2'b10;
      else             exp_grant = 2'b00;
      exp_ur = (c >= 8 && c <= 10);
      @(negedge clock);
      n_checks++;
      if ({bus.disp_ack, bus.wr_ack} !== exp_grant) begin
        n_errors++;
        $display("FAIL chain_grant_cycle%0d: got dack/wack %b expected %b",
                 c, {bus.disp_ack, bus.wr_ack}, exp_grant);
      end
      n_checks++;
      if (bus.underrun !== exp_ur) begin
        n_errors++;
        $display("FAIL chain_underrun_cycle%0d: got %b expected %b", c, bus.underrun, exp_ur);
      end
      cyc();
    end
    idle_inputs();
    cyc();
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [0:3];
    exp_data[0] = 32'hA0A1A2A3;
    exp_data[1] = 32'hB0B1B2B3;
    exp_data[2] = 32'hC0C1C2C3;
    exp_data[3] = 32'hD0D1D2D3;
    for (int c = 0; c < 7; c++) begin
      bus.disp_req  = (c < 4);
      bus.disp_addr = 17'(c);
      @(negedge clock);
      if (c < 4) begin
        n_checks++;
        if (bus.disp_ack !== 1'b1 || bus.mem_addr !== 17'(c)) begin
          n_errors++;
          $display("FAIL b2b_ack%0d: got ack %b addr %h expected 1 %h",
                   c, bus.disp_ack, bus.mem_addr, 17'(c));
        end
      end
      n_checks++;
      if (c >= 2 && c <= 5) begin
        if (bus.disp_rvalid !== 1'b1 || bus.disp_rdata !== exp_data[c-2]) begin
          n_errors++;
          $display("FAIL b2b_return%0d: got rvalid %b data %h expected 1 %h",
                   c - 2, bus.disp_rvalid, bus.disp_rdata, exp_data[c-2]);
        end
      end else if (bus.disp_rvalid !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_idle_cycle%0d: got rvalid %b expected 0", c, bus.disp_rvalid);
      end
      cyc();
    end
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00010;
    @(negedge clock);
    n_checks++;
    if (bus.disp_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_flight_ack: got %b expected 1", bus.disp_ack);
    end
    cyc();
    bus.disp_req = 1'b0;
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 17'h001FF;
    bus.wr_data  = 32'h1;
    reset        = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({bus.mem_en, bus.wr_ack, bus.disp_ack, bus.disp_rvalid, bus.underrun} !== 5'b0) begin
      n_errors++;
      $display("FAIL rst_flight_outputs: got %b expected 00000",
               {bus.mem_en, bus.wr_ack, bus.disp_ack, bus.disp_rvalid, bus.underrun});
    end
    cyc();
    reset = 1'b0;
    idle_inputs();
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b0 || bus.disp_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_flight_flushed: got rvalid %b data %h expected 0 00000000",
               bus.disp_rvalid, bus.disp_rdata);
    end
    cyc();
    bus.disp_req  = 1'b1;
    bus.disp_addr = 17'h00003;
    @(negedge clock);
    n_checks++;
    if (bus.disp_rvalid !== 1'b0 || bus.disp_ack !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_flight_arb: got rvalid %b dack %b expected 0 1",
               bus.disp_rvalid, bus.disp_ack);
    end
    cyc();
    idle_inputs();
    cyc();
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem_model[i] = 32'h0;
    mem_model[9'h010] = 32'hAABBCCDD;
    mem_model[9'h000] = 32'hA0A1A2A3;
    mem_model[9'h001] = 32'hB0B1B2B3;
    mem_model[9'h002] = 32'hC0C1C2C3;
    mem_model[9'h003] = 32'hD0D1D2D3;
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_single_read();
    test_starvation();
    test_write_then_read();
    test_underrun_chain();
    test_back_to_back();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
